regfile_write_arbiter: RTL and testbench
========================================

// Module: regfile_write_arbiter
// PURPOSE
//  Writer-side front end for the 2R/1W register file. Merges single-cycle pipeline (ALU/load) results
//  and long-latency multiply/divide unit (MDU) results onto the single write port.
//  Holds a pending-write scoreboard so decode can stall on registers owned by in-flight MDU ops.
//  Sits between the WB stage / MDU and the register file write port; its pending outputs feed hazard/stall logic.
// PARAMETERS
//  DEPTH   2   MDU result buffer entries (power of two, >=2)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   asynchronous, active-low reset
//  alu_we       in   1   pipeline result valid this cycle (no backpressure)
//  alu_w        in   5   pipeline destination register
//  alu_data     in   32  pipeline result
//  mdu_valid    in   1   MDU result offered
//  mdu_ready    out  1   buffer can accept (handshake completes when valid&&ready)
//  mdu_w        in   5   MDU destination register
//  mdu_data     in   32  MDU result
//  issue_valid  in   1   MDU op issued this cycle; marks issue_w pending
//  issue_w      in   5   destination of issued MDU op
//  qa, qb       in   5   decode source registers to check
//  pending_a/b  out  1   qa/qb awaiting an MDU write -> stall
//  pending_any  out  1   any scoreboard bit set (fence/drain)
//  rf_we        out  1   register file write enable
//  rf_w         out  5   register file write address
//  rf_data      out  32  register file write data
// BEHAVIOUR
//  - Reset (rst_n=0, async): buffer empty, scoreboard all 0; rf_we=0, rf_w=0, rf_data=0,
//    mdu_ready=1, pending_* = 0. Holds while rst_n low; resumes on first clk edge after release.
//  - Write port (combinational, same cycle): alu write = alu_we && alu_w!=0; it always wins.
//    Else if buffer non-empty, head entry drives rf_* (a "commit") and is popped at the clock edge.
//    Else rf_we=0 and rf_w/rf_data=0.
//  - alu_we=1 with alu_w=0 is not a write and does not block a commit that cycle.
//  - MDU accept: mdu_ready = !full. Accepted entry is pushed at the edge; earliest commit is the next
//    cycle (latency 1 when not blocked). Accepted mdu_w=0 is dropped; it makes no entry or write.
//  - Full with simultaneous pop: mdu_ready stays 0 that cycle (ready is not based on pop).
//  - Buffer order FIFO; pointers wrap modulo DEPTH. Push and pop in the same cycle keep the count.
//  - Scoreboard sb[31:1]: set on issue_valid && issue_w!=0; cleared on commit of head w.
//    Same-cycle set and clear of the same register: set wins (bit stays 1).
//  - pending_a = qa!=0 && sb[qa] && !(commit && head_w==qa); same for b. A commit this cycle reaches
//    readers through the register file write-through bypass, so no stall is needed.
//  - pending_any = |sb (registered bits only).
//  - ALU writes never touch the scoreboard.
//  - Illegal (flagged by assertion, not handled): issue to an already-pending register;
//    ALU write to a pending register; mdu_valid dropped before ready; payload changed while valid&&!ready.
//  - Starvation: continuous ALU writes may hold MDU entries indefinitely. Upstream guarantees bubbles
//    because it stalls on pending_*.
// STRUCTURE
//  - Shared package: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, and typedef wb_entry_t {w, data}.
//  - One sub-module: wb_fifo (DEPTH x wb_entry_t sync FIFO, async active-low reset,
//    push/pop/full/empty/head). Arbiter and scoreboard stay in this module.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> rf_we=0, mdu_ready=1, pending_any=0 without waiting for a clk edge.
//  2 Issue r5; next cycle qa=5 -> pending_a=1. MDU r5=0xDEADBEEF accepted -> next cycle rf_we=1,
//    rf_w=5, rf_data=0xDEADBEEF, pending_a=0; following cycle pending_any=0.
//  3 ALU writes r3=0x11 every cycle while MDU offers r7,r8,r9 -> two entries buffered, then mdu_ready=0.
//    Drop alu_we -> r7 and r8 commit on consecutive cycles, then r9.
//  4 Commit r9 while issue_valid r9 in the same cycle -> sb[9] stays 1 and pending_any stays 1.
//  5 alu_we=1 with alu_w=0 while head holds r4=0x44 -> rf_we=1, rf_w=4. MDU r0 accepted -> no write,
//    buffer count unchanged.
//  6 Random ALU/MDU/issue mix against a reference register model -> final register contents match,
//    and no read of a pending register occurs without a stall.

Source files
------------

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types for the register file write arbiter.
// Widths and the buffered MDU write-back record.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] w;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_write_arbiter_wb_fifo.sv
// Small synchronous FIFO of pending MDU write-back entries.
// Pointers wrap modulo DEPTH; head is valid whenever !empty.
module wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  wb_entry_t din,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = count == FULL_CNT;
    assign empty   = count == '0;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges pipeline and MDU results onto the single RF write port.
// Tracks MDU-owned destinations so decode can stall on them.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alu_we,
    input  logic [REG_ADDR_W-1:0] alu_w,
    input  logic [DATA_W-1:0]     alu_data,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_w,
    input  logic [DATA_W-1:0]     mdu_data,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_w,
    input  logic [REG_ADDR_W-1:0] qa,
    input  logic [REG_ADDR_W-1:0] qb,
    output logic                  pending_a,
    output logic                  pending_b,
    output logic                  pending_any,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_w,
    output logic [DATA_W-1:0]     rf_data
);

    logic                alu_wr;
    logic                commit;
    logic                full;
    logic                empty;
    logic                push;
    wb_entry_t           head;
    wb_entry_t           din;
    logic [NUM_REGS-1:0] sb;
    logic [NUM_REGS-1:0] sb_next;

    // Pipeline writes are gated by reset so the port is quiet while held.
    assign alu_wr    = rst_n && alu_we && alu_w != '0;
    assign commit    = !alu_wr && !empty;
    assign mdu_ready = !full;
    assign push      = mdu_valid && !full && mdu_w != '0;
    assign din       = '{w: mdu_w, data: mdu_data};
    assign rf_we     = alu_wr || commit;

    always_comb begin
        rf_w    = '0;
        rf_data = '0;
        unique case (1'b1)
            alu_wr: begin
                rf_w    = alu_w;
                rf_data = alu_data;
            end
            commit: begin
                rf_w    = head.w;
                rf_data = head.data;
            end
            default: ;
        endcase
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (din),
        .pop   (commit),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // An issue in the same cycle as a commit of that register keeps it set.
    always_comb begin
        sb_next = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            sb_next[i] = (sb[i] && !(commit && head.w == REG_ADDR_W'(i)))
                       || (issue_valid && issue_w == REG_ADDR_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    // A same-cycle commit reaches readers through the RF bypass.
    assign pending_a   = qa != '0 && sb[qa] && !(commit && head.w == qa);
    assign pending_b   = qb != '0 && sb[qb] && !(commit && head.w == qb);
    assign pending_any = |sb;

    a_issue_free: assert property (@(posedge clk) disable iff (!rst_n)
        issue_valid && issue_w != '0
        |-> !sb[issue_w] || (commit && head.w == issue_w));

    a_alu_free: assert property (@(posedge clk) disable iff (!rst_n)
        alu_wr |-> !sb[alu_w]);

    a_mdu_hold: assert property (@(posedge clk) disable iff (!rst_n)
        mdu_valid && !mdu_ready
        |=> mdu_valid && $stable(mdu_w) && $stable(mdu_data));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: table vectors, directed
// corner sequences and a queue-based random reference model.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_we, mdu_valid, mdu_ready, issue_valid;
    logic [4:0]  alu_w, mdu_w, issue_w, qa, qb, rf_w;
    logic [31:0] alu_data, mdu_data, rf_data;
    logic        pending_a, pending_b, pending_any, rf_we;

    int vectors = 0;
    int miscompares = 0;

    regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_we(alu_we), .alu_w(alu_w), .alu_data(alu_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
        .mdu_w(mdu_w), .mdu_data(mdu_data),
        .issue_valid(issue_valid), .issue_w(issue_w),
        .qa(qa), .qb(qb),
        .pending_a(pending_a), .pending_b(pending_b),
        .pending_any(pending_any),
        .rf_we(rf_we), .rf_w(rf_w), .rf_data(rf_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        a_we;
        logic [4:0]  a_w;
        logic [31:0] a_d;
        logic        m_v;
        logic [4:0]  m_w;
        logic [31:0] m_d;
        logic        i_v;
        logic [4:0]  i_w;
        logic [4:0]  q;
        logic        e_we;
        logic [4:0]  e_w;
        logic [31:0] e_d;
        logic        e_rdy;
        logic        e_pa;
        logic        e_pany;
    } vec_t;

    vec_t tbl[7];

    wb_entry_t   mq[$];
    logic [31:0] sb_m;
    logic [31:0] regs_m [32];
    logic [31:0] shadow [32];
    int          inflight[$];
    bit          offering;
    wb_entry_t   off;

    function automatic vec_t mk(
        bit awe, int aw, int ad, bit mv, int mw, int md, bit iv, int iw,
        int q, bit ewe, int ew, int ed, bit erdy, bit epa, bit epany);
        vec_t v;
        v.a_we = awe; v.a_w = 5'(aw); v.a_d = 32'(ad);
        v.m_v = mv;   v.m_w = 5'(mw); v.m_d = 32'(md);
        v.i_v = iv;   v.i_w = 5'(iw); v.q = 5'(q);
        v.e_we = ewe; v.e_w = 5'(ew); v.e_d = 32'(ed);
        v.e_rdy = erdy; v.e_pa = epa; v.e_pany = epany;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        alu_we = 0; alu_w = 0; alu_data = 0;
        mdu_valid = 0; mdu_w = 0; mdu_data = 0;
        issue_valid = 0; issue_w = 0; qa = 0; qb = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        mq.delete();
        inflight.delete();
        offering = 0;
        sb_m = 0;
        for (int i = 0; i < 32; i++) begin
            regs_m[i] = 0;
            shadow[i] = 0;
        end
    endtask

    // Predicts this cycle's outputs from the rules, then advances the model.
    task automatic model_step(output bit accepted);
        bit          aw, cm, rdy, pa, pb;
        logic [4:0]  ew;
        logic [31:0] ed;
        aw  = alu_we && alu_w != 0;
        cm  = !aw && mq.size() > 0;
        rdy = mq.size() < DEPTH;
        ew  = aw ? alu_w : (cm ? mq[0].w : 5'd0);
        ed  = aw ? alu_data : (cm ? mq[0].data : 32'd0);
        pa  = qa != 0 && sb_m[qa] && !(cm && mq[0].w == qa);
        pb  = qb != 0 && sb_m[qb] && !(cm && mq[0].w == qb);
        chk("rnd_rf_we", rf_we, aw || cm);
        chk("rnd_rf_w", rf_w, ew);
        chk("rnd_rf_data", rf_data, ed);
        chk("rnd_ready", mdu_ready, rdy);
        chk("rnd_pend_a", pending_a, pa);
        chk("rnd_pend_b", pending_b, pb);
        chk("rnd_pend_any", pending_any, sb_m != 0);
        if (rf_we) shadow[rf_w] = rf_data;
        if (aw) regs_m[alu_w] = alu_data;
        if (cm) begin
            regs_m[mq[0].w] = mq[0].data;
            sb_m[mq[0].w] = 1'b0;
            void'(mq.pop_front());
        end
        accepted = mdu_valid && rdy;
        if (accepted && mdu_w != 0) mq.push_back('{w: mdu_w, data: mdu_data});
        if (issue_valid && issue_w != 0) sb_m[issue_w] = 1'b1;
    endtask

    task automatic rand_cycle(input bit busy);
        bit acc;
        int iw, aw;
        if (!offering) begin
            if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
                off.w = 5'(inflight.pop_front());
                off.data = $urandom;
                offering = 1;
            end else if (busy && $urandom_range(0, 19) == 0) begin
                off.w = 0;
                off.data = $urandom;
                offering = 1;
            end
        end
        mdu_valid = offering;
        mdu_w     = offering ? off.w : 5'($urandom);
        mdu_data  = offering ? off.data : $urandom;
        iw = $urandom_range(0, 31);
        issue_valid = busy && $urandom_range(0, 3) == 0 && !sb_m[iw];
        issue_w = 5'(iw);
        aw = $urandom_range(0, 31);
        if (sb_m[aw]) aw = 0;
        alu_we = busy && $urandom_range(0, 1) == 1;
        alu_w = 5'(aw);
        alu_data = $urandom;
        qa = 5'($urandom_range(0, 31));
        qb = 5'($urandom_range(0, 31));
        #1;
        model_step(acc);
        if (acc) offering = 0;
        if (issue_valid && iw != 0) inflight.push_back(iw);
        tick();
    endtask

    initial begin
        bit done;
        idle();

        // Reset values, then async reset in the middle of traffic.
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_ready", mdu_ready, 1);
        chk("rst_pend_any", pending_any, 0);
        @(negedge clk);
        rst_n = 1;
        alu_we = 1; alu_w = 3; alu_data = 32'h11;
        mdu_valid = 1; mdu_w = 7; mdu_data = 32'h77;
        issue_valid = 1; issue_w = 5;
        tick();
        issue_valid = 0; qa = 5;
        #1;
        chk("t1_pend_any", pending_any, 1);
        chk("t1_rf_we", rf_we, 1);
        tick();
        #1;
        chk("t1_full", mdu_ready, 0);
        #1 rst_n = 0;
        #1;
        chk("t1_async_rf_we", rf_we, 0);
        chk("t1_async_ready", mdu_ready, 1);
        chk("t1_async_pend_any", pending_any, 0);
        chk("t1_async_pend_a", pending_a, 0);
        idle();
        tick();
        rst_n = 1;

        // Issue r5, MDU result commits the cycle after acceptance.
        issue_valid = 1; issue_w = 5;
        #1 chk("t2_pend_any0", pending_any, 0);
        tick();
        issue_valid = 0; qa = 5; qb = 5;
        mdu_valid = 1; mdu_w = 5; mdu_data = 32'hDEADBEEF;
        #1;
        chk("t2_pend_a", pending_a, 1);
        chk("t2_pend_b", pending_b, 1);
        chk("t2_ready", mdu_ready, 1);
        chk("t2_no_write", rf_we, 0);
        tick();
        mdu_valid = 0;
        #1;
        chk("t2_commit_we", rf_we, 1);
        chk("t2_commit_w", rf_w, 5);
        chk("t2_commit_data", rf_data, 32'hDEADBEEF);
        chk("t2_bypass_a", pending_a, 0);
        chk("t2_still_any", pending_any, 1);
        tick();
        #1 chk("t2_clear_any", pending_any, 0);
        idle();

        // ALU hogs the port, buffer fills, then drains in order.
        tbl[0] = mk(1, 3, 'h11, 1, 7, 'h77, 0, 0, 9, 1, 3, 'h11, 1, 0, 0);
        tbl[1] = mk(1, 3, 'h11, 1, 8, 'h88, 0, 0, 9, 1, 3, 'h11, 1, 0, 0);
        tbl[2] = mk(1, 3, 'h11, 1, 9, 'h99, 0, 0, 9, 1, 3, 'h11, 0, 0, 0);
        tbl[3] = mk(0, 0, 0, 1, 9, 'h99, 0, 0, 9, 1, 7, 'h77, 0, 0, 0);
        tbl[4] = mk(0, 0, 0, 1, 9, 'h99, 0, 0, 9, 1, 8, 'h88, 1, 0, 0);
        tbl[5] = mk(0, 0, 0, 0, 0, 0, 1, 9, 9, 1, 9, 'h99, 1, 0, 0);
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            alu_we = tbl[i].a_we; alu_w = tbl[i].a_w; alu_data = tbl[i].a_d;
            mdu_valid = tbl[i].m_v; mdu_w = tbl[i].m_w; mdu_data = tbl[i].m_d;
            issue_valid = tbl[i].i_v; issue_w = tbl[i].i_w;
            qa = tbl[i].q; qb = 0;
            #1;
            chk($sformatf("tbl%0d_rf_we", i), rf_we, tbl[i].e_we);
            chk($sformatf("tbl%0d_rf_w", i), rf_w, tbl[i].e_w);
            chk($sformatf("tbl%0d_rf_data", i), rf_data, tbl[i].e_d);
            chk($sformatf("tbl%0d_ready", i), mdu_ready, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_pend_a", i), pending_a, tbl[i].e_pa);
            chk($sformatf("tbl%0d_pend_any", i), pending_any, tbl[i].e_pany);
            tick();
        end
        idle();

        // Zero-destination ALU does not block; r0 MDU result is dropped.
        mdu_valid = 1; mdu_w = 4; mdu_data = 32'h44;
        #1 chk("t5_push_ready", mdu_ready, 1);
        tick();
        alu_we = 1; alu_w = 0; alu_data = 32'hBAD;
        mdu_valid = 1; mdu_w = 0; mdu_data = 32'h1234;
        #1;
        chk("t5_rf_we", rf_we, 1);
        chk("t5_rf_w", rf_w, 4);
        chk("t5_rf_data", rf_data, 32'h44);
        tick();
        idle();
        #1;
        chk("t5_r0_dropped_we", rf_we, 0);
        chk("t5_r0_dropped_w", rf_w, 0);
        tick();
        mdu_valid = 1; mdu_w = 9; mdu_data = 32'h99AA;
        tick();
        idle(); qa = 9;
        #1;
        chk("t5_r9_w", rf_w, 9);
        chk("t5_r9_bypass", pending_a, 0);
        chk("t5_r9_any", pending_any, 1);
        tick();
        #1 chk("t5_r9_cleared", pending_any, 0);

        // Random traffic against the reference model.
        #1 rst_n = 0;
        idle();
        model_reset();
        tick();
        rst_n = 1;
        for (int c = 0; c < 3000; c++) rand_cycle(1);
        done = 0;
        for (int k = 0; k < 500 && !done; k++) begin
            done = !offering && inflight.size() == 0 && mq.size() == 0;
            if (!done) rand_cycle(0);
        end
        chk("drain_done", done, 1);
        idle();
        #1 chk("final_pend_any", pending_any, 0);
        for (int r = 1; r < 32; r++) begin
            chk($sformatf("final_r%0d", r), shadow[r], regs_m[r]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
